// File: rtl/shifter_pipe_pkg.sv
// Shared types for the pipelined shifter: op encoding, per-level pipeline record,
// and the helper that locates the last log-stage feeding each register level.
package shifter_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int MAX_SAW   = 6;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  // Sized for the widest build; narrower builds zero-extend into it.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic [MAX_SAW-1:0]   sa;
    op_t                  op;
    logic                 cout;
    logic                 valid;
  } pipe_rec_t;

  function automatic int lvl_last_stage(input int lvl, input int reg_every, input int saw);
    int last;
    last = (lvl + 1) * reg_every;
    if (last > saw) last = saw;
    return last - 1;
  endfunction

endpackage

// File: rtl/shifter_pipe_if.sv
// Operand/result handshake bundle for shifter_pipe; master drives operands and
// consumes results, slave is the shifter itself.
interface shifter_pipe_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
);
  localparam int SAW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [SAW-1:0]   sa;
  op_t              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sh;
  logic             cout;

  modport master (
    output in_valid, x, sa, op, out_ready,
    input  in_ready, out_valid, sh, cout
  );

  modport slave (
    input  in_valid, x, sa, op, out_ready,
    output in_ready, out_valid, sh, cout
  );

endinterface

// File: rtl/shifter_pipe_stage.sv
// One combinational log-shift stage (shift by DIST when enabled) with carry tracking.
// Rotate is built only when SHIFTER_PIPE_ROTATE_EN is defined; otherwise ROR acts as SRL.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  op_t              i_op,
  input  logic             i_cout,
  output logic [WIDTH-1:0] o_data,
  output logic             o_cout
);

  // Stages run MSB-first, so the last enabled stage owns the final carry.
  always_comb begin
    o_data = i_data;
    o_cout = i_cout;
    if (i_en) begin
      case (i_op)
        OP_SLL: begin
          o_data = i_data << DIST;
          o_cout = i_data[WIDTH-DIST];
        end
        OP_SRA: begin
          o_data = {{DIST{i_data[WIDTH-1]}}, i_data[WIDTH-1:DIST]};
          o_cout = i_data[DIST-1];
        end
`ifdef SHIFTER_PIPE_ROTATE_EN
        OP_ROR: begin
          o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
          o_cout = i_data[DIST-1];
        end
`endif
        default: begin
          o_data = i_data >> DIST;
          o_cout = i_data[DIST-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: SAW log-stages with a register level every REG_EVERY stages
// and a bubble-collapsing valid/ready chain. ROR needs SHIFTER_PIPE_ROTATE_EN (see shifter_stage).
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1
) (
  input logic           i_clk,
  input logic           i_rst,
  shifter_pipe_if.slave bus
);

  localparam int SAW = $clog2(WIDTH);
  localparam int L   = (SAW + REG_EVERY - 1) / REG_EVERY;

  pipe_rec_t        r_lvl  [L];
  pipe_rec_t        w_src  [L];
  pipe_rec_t        w_next [L];
  logic [L-1:0]     w_load;
  logic [WIDTH-1:0] w_stage_data [SAW];
  logic             w_stage_cout [SAW];

  for (genvar s = 0; s < SAW; s++) begin : g_stage
    localparam int G = s / REG_EVERY;
    localparam int K = SAW - 1 - s;
    logic [WIDTH-1:0] w_in;
    logic             w_cin;
    if (s % REG_EVERY == 0) begin : g_head
      assign w_in  = w_src[G].data[WIDTH-1:0];
      assign w_cin = w_src[G].cout;
    end else begin : g_body
      assign w_in  = w_stage_data[s-1];
      assign w_cin = w_stage_cout[s-1];
    end
    shifter_stage #(.WIDTH(WIDTH), .DIST(2**K)) u_stage (
      .i_data (w_in),
      .i_en   (w_src[G].sa[K]),
      .i_op   (w_src[G].op),
      .i_cout (w_cin),
      .o_data (w_stage_data[s]),
      .o_cout (w_stage_cout[s])
    );
  end

  for (genvar g = 0; g < L; g++) begin : g_lvl
    localparam int LAST = lvl_last_stage(g, REG_EVERY, SAW);
    logic [MAX_WIDTH-1:0] w_data_ext;
    if (g == 0) begin : g_in
      assign w_src[g] = '{data:  MAX_WIDTH'(bus.x),
                          sa:    MAX_SAW'(bus.sa),
                          op:    bus.op,
                          cout:  1'b0,
                          valid: bus.in_valid};
    end else begin : g_mid
      assign w_src[g] = r_lvl[g-1];
    end
    assign w_data_ext = MAX_WIDTH'(w_stage_data[LAST]);
    assign w_next[g]  = '{data:  w_data_ext,
                          sa:    w_src[g].sa,
                          op:    w_src[g].op,
                          cout:  w_stage_cout[LAST],
                          valid: w_src[g].valid};
  end

  // A level loads when it is empty or everything downstream of it moves this cycle.
  always_comb begin
    logic v_adv;
    w_load = '0;
    v_adv  = bus.out_ready;
    for (int g = L - 1; g >= 0; g--) begin
      w_load[g] = ~r_lvl[g].valid | v_adv;
      v_adv     = w_load[g];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int g = 0; g < L; g++) r_lvl[g] <= '0;
    end else begin
      for (int g = 0; g < L; g++) begin
        if (w_load[g]) r_lvl[g] <= w_next[g];
      end
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_lvl[L-1].valid;
  assign bus.sh        = r_lvl[L-1].data[WIDTH-1:0];
  assign bus.cout      = r_lvl[L-1].cout;

  // Record bits beyond WIDTH/SAW exist only because the record is sized for the widest build.
  logic w_unused_rec;
  always_comb begin
    w_unused_rec = 1'b0;
    for (int g = 0; g < L; g++) w_unused_rec = w_unused_rec ^ (^r_lvl[g]);
  end

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined barrel shifter for the datapath's shift/rotate unit. It replaces the single-cycle 32-bit combinational shifter. It adds configurable width, configurable pipeline register placement, a rotate mode, a carry-out (last bit shifted out), and a valid/ready handshake with full backpressure. It sits between the operand-select stage and the writeback mux, and accepts one operation per cycle.

## Interface
- WIDTH, 32, data width; power of two, 8..64; SAW = log2(WIDTH)
- REG_EVERY, 1, number of log-shift stages between pipeline registers, 1..SAW; L = ceil(SAW/REG_EVERY) register levels
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- In_valid  in  1  input operation present
- In_ready  out  1  block accepts input this cycle
- X  in  WIDTH  operand
- Sa  in  SAW  shift amount, unsigned, 0..WIDTH-1
- Op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- Out_valid  out  1  result present
- Out_ready  in  1  consumer accepts result
- Sh  out  WIDTH  shifted/rotated result
- Cout  out  1  last bit shifted out (see Operation)

## Operation
- Stage k (k = SAW-1 down to 0) conditionally shifts by 2^k when Sa[k]=1. Stages are applied MSB-first.
- Fill bit for SLL and SRL is 0. For SRA it is X[WIDTH-1].
- For ROR, bits leaving the LSB end re-enter at the MSB end.
- A pipeline register level follows every REG_EVERY stages; the last level is the output register. Each level holds data, remaining Sa bits, Op, running Cout, and a valid bit.
- Cout is tracked through the stages as follows:
  - Sa=0: Cout=0.
  - SLL: Cout = X[WIDTH-Sa].
  - SRL/SRA: Cout = X[Sa-1].
  - ROR: Cout = Sh[WIDTH-1].
- Handshake:
  - A transfer occurs on a cycle with valid & ready at that boundary.
  - Level i advances when level i+1 is empty or is advancing itself (bubble-collapsing).
  - In_ready = ~valid0 | advance0. This is combinational from Out_ready through the ready chain; there is no skid buffer.
  - While Out_valid=1 and Out_ready=0, Sh, Cout and Out_valid hold stable.
- Reset clears all valid bits, data, Sh and Cout to 0. Out_valid=0 and In_ready=1 from the first cycle after Reset deasserts.
- Reset asserted mid-operation discards all in-flight operations; no partial result is ever presented.
- Simultaneous input accept and output drain in the same cycle is supported with no bubble.
- Sa values are always in range by width; there is no modulo handling beyond SAW bits.

## Timing
- Latency: a result accepted in cycle t appears with Out_valid=1 in cycle t+L when no stalls occur. With the defaults WIDTH=32 and REG_EVERY=1, L=5.
- Throughput: 1 operation per cycle with Out_ready held high.
- Sh and Cout are driven directly from registers; there is no combinational path from X or Sa to the outputs.
- The only combinational input-to-output path is Out_ready -> In_ready.
- Ordering: results leave in strict acceptance order.

## Configuration
- SHIFTER_PIPE_ROTATE_EN:
  - Defined: Op=11 performs ROR as specified.
  - Undefined: rotate logic is not built and Op=11 behaves exactly as SRL, including Cout.

## Structure
- Package shifter_pkg holds:
  - the Op encoding constants (OP_SLL, OP_SRL, OP_SRA, OP_ROR);
  - the per-level pipeline record type (data, Sa remainder, Op, Cout, valid).
- Sub-module shifter_stage is a purely combinational single log-stage, parametrised by WIDTH and DIST=2^k. Its inputs are data, enable, Op and Cout-in; its outputs are data and Cout-out.
- shifter_pipe generates SAW instances of shifter_stage plus the register levels and handshake logic.

## Test plan
- Reset: assert Reset mid-stream with 3 operations in flight -> Out_valid=0, Sh=0, Cout=0. After release, no stale result appears and In_ready=1.
- Basic ops, WIDTH=32, Out_ready=1, X=0x80000001, Sa=4:
  - SLL -> Sh=0x00000010, Cout=0
  - SRL -> Sh=0x08000000, Cout=0
  - SRA -> Sh=0xF8000000, Cout=0
  - ROR -> Sh=0x18000000, Cout=0
  - Each result appears exactly 5 cycles after acceptance.
- Carry-out: SLL X=0x40000000, Sa=2 -> Sh=0, Cout=1. SRL X=0x00000003, Sa=1 -> Sh=1, Cout=1. Sa=0 with any Op -> Sh=X, Cout=0.
- Backpressure: stream 10 distinct operations back-to-back with Out_ready=0 for cycles 6..9 -> In_ready drops once all 5 levels are full, outputs hold stable, and all 10 results arrive in order with no loss or duplication.
- Configuration: build without SHIFTER_PIPE_ROTATE_EN, Op=11, X=0x80000001, Sa=4 -> Sh=0x08000000, Cout=0.
- Parameters: WIDTH=8, REG_EVERY=3 (L=1), SRA X=0x90, Sa=3 -> Sh=0xF2, Cout=0, appearing 1 cycle after acceptance.
